wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 The block SHALL have clock `clock` and reset `reset`: synchronous, active-high, sampled on posedge clock.
REQ-002 The ports SHALL be:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
REQ-003 Writeback inputs from the MEM/WB register SHALL be:
- wb_next_pc  in  32  PC+4 of the retiring instruction
- wb_alu_out  in  32  ALU result
- wb_mem_out  in  32  load data
- wb_write_reg  in  5  destination register
- wb_reg_src  in  1  1=load data, 0=ALU result
- wb_reg_write  in  1  write request
- wb_jal  in  1  jump-and-link
REQ-004 Read-port inputs from the decode stage SHALL be:
- rs_addr  in  5  read port A address
- rt_addr  in  5  read port B address
REQ-005 Outputs SHALL be:
- rs_data  out  32  read port A data
- rt_data  out  32  read port B data
- wb_data  out  32  selected writeback value, for EX forwarding
- wb_dest  out  5  effective destination
- wb_we  out  1  effective write enable
- write_count  out  32  count of committed writes

Function
REQ-006 wb_data SHALL be combinational:
- wb_next_pc if wb_jal=1
- else wb_mem_out if wb_reg_src=1
- else wb_alu_out.
REQ-007 wb_dest SHALL be 5'd31 when wb_jal=1, else wb_write_reg.
REQ-008 wb_we SHALL be (wb_reg_write | wb_jal) & (wb_dest != 0) & ~reset.
REQ-009 The block SHALL hold a 31-entry x 32-bit register array for registers 1..31.
- Register 0 has no storage and always reads 0.
REQ-010 On posedge clock with wb_we=1, the block SHALL write wb_data to entry wb_dest; the new value SHALL be readable from the next cycle.
REQ-011 rs_data and rt_data SHALL be combinational reads (zero-cycle latency) of the array entry at rs_addr/rt_addr.
REQ-012 Write-through bypass: when wb_we=1 and read address == wb_dest, the port SHALL return wb_data in the same cycle, not the stale array value.
REQ-013 Either read port addressing 0 SHALL return 32'h0 regardless of any write or bypass.
REQ-014 Both ports reading the same address SHALL return identical data, with the bypass applied to both.
REQ-015 Writes to register 0 SHALL be discarded and SHALL NOT increment write_count.
- This covers wb_write_reg=0 with wb_reg_write=1.
REQ-016 write_count SHALL be a register that increments by 1 on each posedge with wb_we=1.
- It wraps from 32'hFFFF_FFFF to 0 with no flag.
REQ-017 A jal with wb_reg_write=0 SHALL still write $31 and count.
REQ-018 An instruction with wb_reg_write=0 and wb_jal=0 (bubble) SHALL leave the array and counter unchanged.
REQ-019 There SHALL be no stall or enable input.
- Every cycle is a retire slot, and the inputs are consumed exactly when presented.

Reset
REQ-020 On posedge clock with reset=1, all 31 array entries and write_count SHALL become 0.
REQ-021 While reset=1:
- rs_data, rt_data and wb_we SHALL be 0.
- Any concurrent write request SHALL be dropped.
REQ-022 wb_data and wb_dest SHALL remain purely combinational during reset.
REQ-023 A reset asserted mid-sequence SHALL discard all prior writes.
- The first write after reset deasserts SHALL produce write_count=1.

Verification
REQ-024 Basic write and read:
- Stimulus: reset one cycle; write $5=32'h1234_5678 (reg_src=0, alu_out) with reg_write=1; next cycle rs_addr=5.
- Response: rs_data=32'h1234_5678; write_count=1.
REQ-025 Bypass:
- Stimulus: in the same cycle, write $7=32'hDEAD_BEEF from mem_out (reg_src=1) and set rs_addr=rt_addr=7.
- Response: both ports read 32'hDEAD_BEEF before the clock edge; the array holds it after the edge.
REQ-026 Register zero:
- Stimulus: reg_write=1, write_reg=0, alu_out=32'hFFFF_FFFF; rs_addr=0.
- Response: rs_data=0 in the same cycle and the next; wb_we=0; write_count unchanged.
REQ-027 JAL:
- Stimulus: wb_jal=1, reg_write=0, write_reg=4, next_pc=32'h0040_0010.
- Response: wb_dest=31; $31=32'h0040_0010; $4 unchanged; write_count +1.
REQ-028 Bubble and wrap:
- Stimulus: force write_count to 32'hFFFF_FFFF, then issue one valid write and one bubble.
- Response: write_count=0 after the write and still 0 after the bubble.
REQ-029 Reset mid-operation:
- Stimulus: after writing $3=5, assert reset for one cycle together with a write $3=9.
- Response: $3=0; write_count=0; rs/rt outputs are 0 during reset.

Source files
------------

// File: rtl/wb_regfile_if.sv
// wb_regfile_if
// Groups the writeback bus (from the MEM/WB register), the decode-stage read
// addresses and all register-file results into one bundle.
//   master : pipeline side, drives writeback/read-address signals and
//            receives read data, forwarding value and write counter
//   slave  : the register file itself
// Signal summary:
//   wb_next_pc   [31:0]  PC+4 of the retiring instruction
//   wb_alu_out   [31:0]  ALU result
//   wb_mem_out   [31:0]  load data
//   wb_write_reg [4:0]   destination register
//   wb_reg_src           1 = load data, 0 = ALU result
//   wb_reg_write         write request
//   wb_jal               jump-and-link
//   rs_addr/rt_addr      read port A/B addresses
//   rs_data/rt_data      read port A/B data
//   wb_data              selected writeback value (for EX forwarding)
//   wb_dest              effective destination
//   wb_we                effective write enable
//   write_count          number of committed writes
interface wb_regfile_if;
  logic [31:0] wb_next_pc;
  logic [31:0] wb_alu_out;
  logic [31:0] wb_mem_out;
  logic [4:0]  wb_write_reg;
  logic        wb_reg_src;
  logic        wb_reg_write;
  logic        wb_jal;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] wb_data;
  logic [4:0]  wb_dest;
  logic        wb_we;
  logic [31:0] write_count;

  modport master (
    output wb_next_pc, wb_alu_out, wb_mem_out, wb_write_reg,
           wb_reg_src, wb_reg_write, wb_jal, rs_addr, rt_addr,
    input  rs_data, rt_data, wb_data, wb_dest, wb_we, write_count
  );

  modport slave (
    input  wb_next_pc, wb_alu_out, wb_mem_out, wb_write_reg,
           wb_reg_src, wb_reg_write, wb_jal, rs_addr, rt_addr,
    output rs_data, rt_data, wb_data, wb_dest, wb_we, write_count
  );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile
// Writeback stage plus 31x32 register file with write-through bypass.
// Every cycle is a retire slot: the writeback value is selected, the
// effective destination/enable derived, and the selected value written on
// the next rising clock. Register 0 has no storage and always reads zero.
// Ports:
//   clock  system clock
//   reset  synchronous, active-high; clears array and write counter, forces
//          read data and write enable low while asserted
//   bus    wb_regfile_if.slave, writeback inputs, read addresses and results
module wb_regfile (
  input  logic          clock,
  input  logic          reset,
  wb_regfile_if.slave   bus
);

  logic [31:0] regArray_q [1:31];
  logic [31:0] writeCount_q;
  logic [31:0] writeCount_d;

  logic [31:0] wbData;
  logic [4:0]  wbDest;
  logic        wbWe;

  // Writeback selection: jal links PC+4 into $31, otherwise load or ALU data.
  always_comb begin
    wbData = bus.wb_alu_out;
    wbDest = bus.wb_write_reg;
    if (bus.wb_jal) begin
      wbData = bus.wb_next_pc;
      wbDest = 5'd31;
    end else if (bus.wb_reg_src) begin
      wbData = bus.wb_mem_out;
    end
  end

  // A jal always links even without wb_reg_write; $0 targets and reset
  // cycles are dropped so neither the array nor the counter move.
  always_comb begin
    wbWe = (bus.wb_reg_write | bus.wb_jal) & (wbDest != 5'd0) & ~reset;
  end

  // Counter wraps naturally through 32-bit overflow.
  always_comb begin
    writeCount_d = writeCount_q;
    if (wbWe) begin
      writeCount_d = writeCount_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) begin
        regArray_q[i] <= 32'h0;
      end
      writeCount_q <= 32'h0;
    end else begin
      if (wbWe) begin
        regArray_q[wbDest] <= wbData;
      end
      writeCount_q <= writeCount_d;
    end
  end

  // Read port A. The bypass lets decode see a value retiring this same cycle.
  always_comb begin
    bus.rs_data = 32'h0;
    if (!reset && bus.rs_addr != 5'd0) begin
      if (wbWe && bus.rs_addr == wbDest) begin
        bus.rs_data = wbData;
      end else begin
        bus.rs_data = regArray_q[bus.rs_addr];
      end
    end
  end

  // Read port B, identical to port A so equal addresses give equal data.
  always_comb begin
    bus.rt_data = 32'h0;
    if (!reset && bus.rt_addr != 5'd0) begin
      if (wbWe && bus.rt_addr == wbDest) begin
        bus.rt_data = wbData;
      end else begin
        bus.rt_data = regArray_q[bus.rt_addr];
      end
    end
  end

  assign bus.wb_data     = wbData;
  assign bus.wb_dest     = wbDest;
  assign bus.wb_we       = wbWe;
  assign bus.write_count = writeCount_q;

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile
// Directed scenarios for basic write/read, bypass, register zero, jal,
// counter wrap and mid-sequence reset, followed by randomized retire traffic
// compared against an array-based reference model of the register file.
module tb_wb_regfile;

  logic clock;
  logic reset;

  wb_regfile_if busIf ();

  wb_regfile dut (
    .clock (clock),
    .reset (reset),
    .bus   (busIf.slave)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int totalChecks = 0;
  int badChecks   = 0;

  // Reference model: architectural register contents and commit counter.
  logic [31:0] modelRegs [0:31];
  logic [31:0] modelCount;

  // Current stimulus as the bench drove it.
  logic        stimReset;
  logic        stimJal;
  logic        stimRegWrite;
  logic        stimRegSrc;
  logic [4:0]  stimWriteReg;
  logic [31:0] stimNextPc;
  logic [31:0] stimAluOut;
  logic [31:0] stimMemOut;
  logic [4:0]  stimRsAddr;
  logic [4:0]  stimRtAddr;

  // Compare one observed value with its expected value and report mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive one retire slot worth of inputs.
  task automatic applyStimulus(input logic rst, input logic jal,
                               input logic regWrite, input logic regSrc,
                               input logic [4:0] writeReg,
                               input logic [31:0] nextPc,
                               input logic [31:0] aluOut,
                               input logic [31:0] memOut,
                               input logic [4:0] rsA, input logic [4:0] rtA);
    stimReset = rst;  stimJal = jal;  stimRegWrite = regWrite;
    stimRegSrc = regSrc;  stimWriteReg = writeReg;  stimNextPc = nextPc;
    stimAluOut = aluOut;  stimMemOut = memOut;
    stimRsAddr = rsA;  stimRtAddr = rtA;
    reset                = rst;
    busIf.wb_jal         = jal;
    busIf.wb_reg_write   = regWrite;
    busIf.wb_reg_src     = regSrc;
    busIf.wb_write_reg   = writeReg;
    busIf.wb_next_pc     = nextPc;
    busIf.wb_alu_out     = aluOut;
    busIf.wb_mem_out     = memOut;
    busIf.rs_addr        = rsA;
    busIf.rt_addr        = rtA;
  endtask

  function automatic logic [31:0] expData();
    if (stimJal) return stimNextPc;
    if (stimRegSrc) return stimMemOut;
    return stimAluOut;
  endfunction

  function automatic logic [4:0] expDest();
    return stimJal ? 5'd31 : stimWriteReg;
  endfunction

  function automatic logic expWe();
    return (stimRegWrite || stimJal) && expDest() != 5'd0 && !stimReset;
  endfunction

  function automatic logic [31:0] expRead(input logic [4:0] addr);
    if (stimReset || addr == 5'd0) return 32'h0;
    if (expWe() && addr == expDest()) return expData();
    return modelRegs[addr];
  endfunction

  // Check every output against the model for the current stimulus.
  task automatic checkAll(input string tag);
    checkOutput({tag, ".wb_data"}, busIf.wb_data, expData());
    checkOutput({tag, ".wb_dest"}, {27'h0, busIf.wb_dest}, {27'h0, expDest()});
    checkOutput({tag, ".wb_we"}, {31'h0, busIf.wb_we}, {31'h0, expWe()});
    checkOutput({tag, ".rs_data"}, busIf.rs_data, expRead(stimRsAddr));
    checkOutput({tag, ".rt_data"}, busIf.rt_data, expRead(stimRtAddr));
    checkOutput({tag, ".write_count"}, busIf.write_count, modelCount);
  endtask

  // Advance through one rising edge, commit into the model, settle mid-cycle.
  task automatic clockEdge();
    logic        we;
    logic [4:0]  dest;
    logic [31:0] data;
    we = expWe();  dest = expDest();  data = expData();
    @(posedge clock);
    if (stimReset) begin
      for (int i = 0; i < 32; i++) modelRegs[i] = 32'h0;
      modelCount = 32'h0;
    end else if (we) begin
      modelRegs[dest] = data;
      modelCount = modelCount + 32'd1;
    end
    @(negedge clock);
  endtask

  task automatic bubble(input logic [4:0] rsA, input logic [4:0] rtA);
    applyStimulus(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, rsA, rtA);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) modelRegs[i] = 32'hx;
    modelCount = 32'hx;

    // Reset for one cycle; read data and enable are held low meanwhile.
    applyStimulus(1, 0, 1, 0, 5'd5, 32'h0, 32'h5555_0000, 32'h0, 5'd5, 5'd5);
    #1;
    checkOutput("reset.rs_data", busIf.rs_data, 32'h0);
    checkOutput("reset.wb_we", {31'h0, busIf.wb_we}, 32'h0);
    clockEdge();
    bubble(5'd5, 5'd9);
    checkAll("reset_state");
    checkOutput("reset_state.count", busIf.write_count, 32'h0);

    // Basic write and read.
    applyStimulus(0, 0, 1, 0, 5'd5, 32'h0, 32'h1234_5678, 32'h0, 5'd1, 5'd2);
    #1;
    checkAll("basic_wr");
    clockEdge();
    bubble(5'd5, 5'd0);
    checkAll("basic_rd");
    checkOutput("basic.rs_data", busIf.rs_data, 32'h1234_5678);
    checkOutput("basic.count", busIf.write_count, 32'd1);

    // Same-cycle bypass on both ports from load data.
    applyStimulus(0, 0, 1, 1, 5'd7, 32'h0, 32'h0BAD_0BAD, 32'hDEAD_BEEF, 5'd7, 5'd7);
    #1;
    checkAll("bypass");
    checkOutput("bypass.rs_data", busIf.rs_data, 32'hDEAD_BEEF);
    checkOutput("bypass.rt_data", busIf.rt_data, 32'hDEAD_BEEF);
    clockEdge();
    bubble(5'd7, 5'd7);
    checkOutput("bypass.array", busIf.rs_data, 32'hDEAD_BEEF);

    // Writes to register zero are dropped and not counted.
    applyStimulus(0, 0, 1, 0, 5'd0, 32'h0, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd0);
    #1;
    checkAll("zero_wr");
    checkOutput("zero.rs_same", busIf.rs_data, 32'h0);
    checkOutput("zero.wb_we", {31'h0, busIf.wb_we}, 32'h0);
    clockEdge();
    bubble(5'd0, 5'd5);
    checkOutput("zero.rs_next", busIf.rs_data, 32'h0);
    checkOutput("zero.count", busIf.write_count, 32'd2);

    // Jal without reg_write links into $31 and leaves $4 alone.
    applyStimulus(0, 0, 1, 0, 5'd4, 32'h0, 32'hAAAA_5555, 32'h0, 5'd0, 5'd0);
    #1;
    clockEdge();
    applyStimulus(0, 1, 0, 0, 5'd4, 32'h0040_0010, 32'h11, 32'h22, 5'd4, 5'd31);
    #1;
    checkAll("jal");
    checkOutput("jal.wb_dest", {27'h0, busIf.wb_dest}, 32'd31);
    clockEdge();
    bubble(5'd31, 5'd4);
    checkOutput("jal.r31", busIf.rs_data, 32'h0040_0010);
    checkOutput("jal.r4", busIf.rt_data, 32'hAAAA_5555);
    checkOutput("jal.count", busIf.write_count, 32'd4);

    // Counter wrap: preload all-ones, then a valid write and a bubble.
    force dut.writeCount_q = 32'hFFFF_FFFF;
    #1;
    release dut.writeCount_q;
    modelCount = 32'hFFFF_FFFF;
    applyStimulus(0, 0, 1, 0, 5'd9, 32'h0, 32'h0000_0099, 32'h0, 5'd9, 5'd0);
    #1;
    clockEdge();
    bubble(5'd9, 5'd0);
    checkOutput("wrap.after_write", busIf.write_count, 32'h0);
    clockEdge();
    bubble(5'd9, 5'd0);
    checkOutput("wrap.after_bubble", busIf.write_count, 32'h0);

    // Reset mid-operation drops its concurrent write and clears prior ones.
    applyStimulus(0, 0, 1, 0, 5'd3, 32'h0, 32'd5, 32'h0, 5'd0, 5'd0);
    #1;
    clockEdge();
    applyStimulus(1, 0, 1, 0, 5'd3, 32'h0, 32'd9, 32'h0, 5'd3, 5'd3);
    #1;
    checkAll("midreset");
    checkOutput("midreset.rs", busIf.rs_data, 32'h0);
    checkOutput("midreset.rt", busIf.rt_data, 32'h0);
    checkOutput("midreset.wb_data", busIf.wb_data, 32'd9);
    clockEdge();
    bubble(5'd3, 5'd7);
    checkOutput("midreset.r3", busIf.rs_data, 32'h0);
    checkOutput("midreset.r7", busIf.rt_data, 32'h0);
    checkOutput("midreset.count", busIf.write_count, 32'h0);
    applyStimulus(0, 0, 1, 0, 5'd12, 32'h0, 32'h0000_0C0C, 32'h0, 5'd0, 5'd0);
    #1;
    clockEdge();
    bubble(5'd12, 5'd0);
    checkOutput("midreset.first_count", busIf.write_count, 32'd1);

    // Randomized retire traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic        rRst, rJal, rWr, rSrc;
      logic [4:0]  rDest, rA, rB;
      rRst  = ($urandom_range(0, 31) == 0);
      rJal  = ($urandom_range(0, 3) == 0);
      rWr   = $urandom_range(0, 1) == 1;
      rSrc  = $urandom_range(0, 1) == 1;
      rDest = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      rA    = 5'($urandom_range(0, 31));
      rB    = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) rA = rJal ? 5'd31 : rDest;
      if ($urandom_range(0, 3) == 0) rB = rA;
      applyStimulus(rRst, rJal, rWr, rSrc, rDest, $urandom, $urandom, $urandom, rA, rB);
      #1;
      checkAll($sformatf("rand%0d", n));
      clockEdge();
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

  // Guard against the run never reaching its summary.
  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
